// File: rtl/dht_pkg.sv
// dht_pkg: shared FSM state type, error codes and timing helper for dht_sensor_if
package dht_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_START_LOW, S_RELEASE, S_RESP_LOW, S_RESP_HIGH,
    S_BIT_LOW, S_BIT_HIGH, S_CHECK, S_HOLDOFF
  } dht_state_t;
  localparam logic [1:0] DHT_ERR_NONE   = 2'd0;
  localparam logic [1:0] DHT_ERR_NORESP = 2'd1;
  localparam logic [1:0] DHT_ERR_BIT    = 2'd2;
  localparam logic [1:0] DHT_ERR_CSUM   = 2'd3;
  function automatic longint unsigned us_to_cyc(input int unsigned clk_hz, input longint unsigned us);
    return 64'(clk_hz) * us / 64'd1_000_000;
  endfunction
endpackage

// File: rtl/dht_line_sync.sv
// dht_line_sync: 2-flop synchroniser plus deglitch filter for the sensor line
// Ports: clk, rst_n (async, active-low), din (raw line) -> level (filtered), rise/fall (1-cycle strobes)
module dht_line_sync #(
  parameter int FILT_CYC = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);
  localparam int CW = FILT_CYC > 1 ? $clog2(FILT_CYC) : 1;
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  logic flip;
  // a new level is taken only after FILT_CYC consecutive differing samples
  assign flip = (sync[1] != level) && (cnt == CW'(FILT_CYC - 1));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync  <= 2'b11;
      level <= 1'b1;
      cnt   <= '0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync  <= {sync[0], din};
      cnt   <= (sync[1] == level || flip) ? '0 : cnt + 1'b1;
      level <= flip ? sync[1] : level;
      rise  <= flip & sync[1];
      fall  <= flip & ~sync[1];
    end
endmodule

// File: rtl/dht_sensor_if.sv
// dht_sensor_if: DHT11/DHT22 single-wire reader with timeouts, checksum and inter-read hold-off
// Ports: clk, rst_n (async, active-low); start/mode request a read; dht_io is the open-drain line;
//        ready/busy/done/ok/err report status; hum_raw/temp_raw hold the last good frame.
module dht_sensor_if import dht_pkg::*; #(
  parameter int unsigned CLK_HZ          = 100_000_000,
  parameter int unsigned START_LOW_US_11 = 18000,
  parameter int unsigned START_LOW_US_22 = 1000,
  parameter int unsigned BIT1_THRESH_US  = 40,
  parameter int unsigned TIMEOUT_US      = 200,
  parameter int unsigned HOLDOFF_MS_11   = 1000,
  parameter int unsigned HOLDOFF_MS_22   = 2000,
  parameter int unsigned FILT_CYC        = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        mode,
  inout  logic        dht_io,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic        ok,
  output logic [1:0]  err,
  output logic [15:0] hum_raw,
  output logic [15:0] temp_raw
);
  localparam longint unsigned HO11 = us_to_cyc(CLK_HZ, 64'(HOLDOFF_MS_11) * 64'd1000);
  localparam longint unsigned HO22 = us_to_cyc(CLK_HZ, 64'(HOLDOFF_MS_22) * 64'd1000);
  localparam longint unsigned HO_MAX = HO11 > HO22 ? HO11 : HO22;
  localparam int W = $clog2(HO_MAX + 1);
  localparam logic [W-1:0] HO11_C = W'(HO11);
  localparam logic [W-1:0] HO22_C = W'(HO22);
  localparam logic [W-1:0] ST11_C = W'(us_to_cyc(CLK_HZ, 64'(START_LOW_US_11)));
  localparam logic [W-1:0] ST22_C = W'(us_to_cyc(CLK_HZ, 64'(START_LOW_US_22)));
  localparam logic [W-1:0] REL_C  = W'(us_to_cyc(CLK_HZ, 64'd30));
  localparam logic [W-1:0] THR_C  = W'(us_to_cyc(CLK_HZ, 64'(BIT1_THRESH_US)));
  localparam logic [W-1:0] TO_C   = W'(us_to_cyc(CLK_HZ, 64'(TIMEOUT_US)));

  dht_state_t state, state_n;
  logic [W-1:0] timer, ho_cnt, ho_lim, st_lim;
  logic [5:0] bit_cnt;
  logic [39:0] shreg;
  logic [7:0] csum;
  logic mode_q, drv, level, rise, fall, to_hit, csum_ok;
  logic accept, shift, abort_resp, abort_bit;

  dht_line_sync #(.FILT_CYC(FILT_CYC)) u_sync (
    .clk(clk), .rst_n(rst_n), .din(dht_io), .level(level), .rise(rise), .fall(fall)
  );

  assign dht_io  = drv ? 1'b0 : 1'bz;
  assign ho_lim  = mode_q ? HO22_C : HO11_C;
  assign st_lim  = mode_q ? ST22_C : ST11_C;
  assign to_hit  = timer == TO_C - 1'b1;
  assign csum    = shreg[39:32] + shreg[31:24] + shreg[23:16] + shreg[15:8];
  assign csum_ok = csum == shreg[7:0];

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= state_n;

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:      state_n = start ? S_START_LOW : S_IDLE;
      S_START_LOW: state_n = timer == st_lim - 1'b1 ? S_RELEASE : S_START_LOW;
      S_RELEASE:   state_n = timer == REL_C - 1'b1 ? S_RESP_LOW : S_RELEASE;
      S_RESP_LOW:  state_n = !level ? S_RESP_HIGH : to_hit ? S_HOLDOFF : S_RESP_LOW;
      // entered while the line is low, so a fall strobe implies the high phase was seen
      S_RESP_HIGH: state_n = fall ? S_BIT_LOW : to_hit ? S_HOLDOFF : S_RESP_HIGH;
      S_BIT_LOW:   state_n = rise ? S_BIT_HIGH : to_hit ? S_HOLDOFF : S_BIT_LOW;
      S_BIT_HIGH:  state_n = fall ? (bit_cnt == 6'd39 ? S_CHECK : S_BIT_LOW) : to_hit ? S_HOLDOFF : S_BIT_HIGH;
      S_CHECK:     state_n = S_HOLDOFF;
      S_HOLDOFF:   state_n = ho_cnt >= ho_lim - 1'b1 ? S_IDLE : S_HOLDOFF;
      default:     state_n = S_IDLE;
    endcase
  end

  always_comb begin
    ready      = state == S_IDLE;
    busy       = !(state == S_IDLE || state == S_HOLDOFF);
    accept     = state == S_IDLE && start;
    shift      = state == S_BIT_HIGH && fall;
    abort_resp = state_n == S_HOLDOFF && (state == S_RESP_LOW || state == S_RESP_HIGH);
    abort_bit  = state_n == S_HOLDOFF && (state == S_BIT_LOW || state == S_BIT_HIGH);
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      timer    <= '0;
      ho_cnt   <= '0;
      mode_q   <= 1'b0;
      drv      <= 1'b0;
      bit_cnt  <= '0;
      shreg    <= '0;
      done     <= 1'b0;
      ok       <= 1'b0;
      err      <= DHT_ERR_NONE;
      hum_raw  <= '0;
      temp_raw <= '0;
    end else begin
      // timer restarts on every state change, so in BIT_HIGH it holds the high time so far
      timer    <= state_n != state ? '0 : timer + 1'b1;
      ho_cnt   <= accept ? '0 : ho_cnt != ho_lim ? ho_cnt + 1'b1 : ho_cnt;
      mode_q   <= accept ? mode : mode_q;
      drv      <= state == S_START_LOW;
      bit_cnt  <= state == S_RESP_HIGH ? '0 : shift ? bit_cnt + 1'b1 : bit_cnt;
      shreg    <= shift ? {shreg[38:0], timer >= THR_C} : shreg;
      done     <= state_n == S_HOLDOFF && state != S_HOLDOFF;
      ok       <= accept ? 1'b0 : state == S_CHECK ? csum_ok : ok;
      err      <= accept ? DHT_ERR_NONE : state == S_CHECK ? (csum_ok ? DHT_ERR_NONE : DHT_ERR_CSUM) :
                  abort_resp ? DHT_ERR_NORESP : abort_bit ? DHT_ERR_BIT : err;
      hum_raw  <= state == S_CHECK && csum_ok ? shreg[39:24] : hum_raw;
      temp_raw <= state == S_CHECK && csum_ok ? shreg[23:8] : temp_raw;
    end
endmodule
